// File: rtl/specdrum_fifo.sv
// Specdrum/Covox sample source: CPU port writes are queued in a stereo
// FIFO and replayed at a fixed rate to smooth out CPU timing jitter.
module specdrum_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DIV        = 640
) (
  input  logic       clk,
  input  logic       mrst_n,
  input  logic [7:0] a,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic [7:0] specdrum_left,
  output logic [7:0] specdrum_right
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [CW-1:0]         count;
  logic [15:0]           presc;
  logic [7:0]            left_stage;
  logic                  ovf;
  logic                  wr_q;
  logic                  rd_q;

  logic        wr_strobe;
  logic        rd_strobe;
  logic        wr_fire;
  logic        rd_sel;
  logic        full;
  logic        empty;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        tick;
  logic [15:0] push_data;

  assign rd_sel    = (a == 8'hDE) & ~iorq_n & ~rd_n;
  assign wr_strobe = ~iorq_n & ~wr_n;
  assign rd_strobe = rd_sel;
  assign wr_fire   = wr_strobe & ~wr_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign push_req  = wr_fire & ((a == 8'hDF) | (a == 8'h4F));
  assign push      = push_req & ~full;
  assign push_data = {(a == 8'hDF) ? din : left_stage, din};

  assign tick = (presc == 16'(DIV - 1));
  assign pop  = tick & ~empty;

  assign dout = {full, empty, ovf, 5'(count)};
  assign oe_n = ~rd_sel;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      presc          <= '0;
      left_stage     <= '0;
      ovf            <= 1'b0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      specdrum_left  <= '0;
      specdrum_right <= '0;
    end else begin
      wr_q  <= wr_strobe;
      rd_q  <= rd_strobe;
      presc <= tick ? '0 : presc + 16'd1;

      if (wr_fire && a == 8'h0F) left_stage <= din;

      // a fresh overflow wins over the clear after a status read
      if (push_req && full) ovf <= 1'b1;
      else if (rd_q && !rd_strobe) ovf <= 1'b0;

      if (push) wptr <= wptr + 1'b1;

      if (pop) begin
        specdrum_left  <= mem[rptr][15:8];
        specdrum_right <= mem[rptr][7:0];
        rptr           <= rptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
